// File: rtl/pic_host_bus_driver.sv
// Host-side initiator for an interrupt controller bus: it writes the ICW sequence
// after reset, then runs queued read/write cycles and the two-pulse INTA_ acknowledge.
module pic_host_bus_driver #(
    parameter logic [7:0] ICW1_VAL = 8'h13,
    parameter logic [7:0] ICW2_VAL = 8'h40,
    parameter logic [7:0] ICW3_VAL = 8'h00,
    parameter logic [7:0] ICW4_VAL = 8'h01,
    parameter int         PULSE_W  = 2,
    parameter int         GAP_W    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       init_done,
    output logic       WR_ENABLE,
    output logic       RD_ENABLE,
    output logic       A0,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    input  logic [7:0] DATA_IN,
    input  logic       INT,
    output logic       INTA_
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW    = $clog2(MAX_W + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);
    localparam logic NEED_ICW3 = ~ICW1_VAL[1];
    localparam logic NEED_ICW4 = ICW1_VAL[0];

    typedef enum logic [3:0] {
        ST_START,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_READY,
        ST_INTA1,
        ST_INTA_GAP,
        ST_INTA2,
        ST_INTA_END,
        ST_VEC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    icw_idx_q, icw_idx_d;
    logic          init_done_q, init_done_d;
    logic          cur_rd_q, cur_rd_d;
    logic          cur_a0_q, cur_a0_d;
    logic [7:0]    cur_data_q, cur_data_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    vec_data_q, vec_data_d;
    logic          vec_valid_q, vec_valid_d;
    logic          wr_en_q, wr_en_d;
    logic          rd_en_q, rd_en_d;
    logic          oe_q, oe_d;
    logic          inta_n_q, inta_n_d;

    logic          nxt_vld;
    logic [1:0]    nxt_idx;

    function automatic logic [7:0] icw_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return ICW1_VAL;
            2'd1:    return ICW2_VAL;
            2'd2:    return ICW3_VAL;
            default: return ICW4_VAL;
        endcase
    endfunction

    // Which ICW follows the current one, skipping ICW3/ICW4 when ICW1 says so.
    always_comb begin
        nxt_vld = 1'b1;
        nxt_idx = icw_idx_q;
        case (icw_idx_q)
            2'd0: nxt_idx = 2'd1;
            2'd1: begin
                if (NEED_ICW3)      nxt_idx = 2'd2;
                else if (NEED_ICW4) nxt_idx = 2'd3;
                else                nxt_vld = 1'b0;
            end
            2'd2: begin
                if (NEED_ICW4) nxt_idx = 2'd3;
                else           nxt_vld = 1'b0;
            end
            default: nxt_vld = 1'b0;
        endcase
    end

    assign cmd_ready = (state_q == ST_READY) && !INT;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        icw_idx_d   = icw_idx_q;
        init_done_d = init_done_q;
        cur_rd_d    = cur_rd_q;
        cur_a0_d    = cur_a0_q;
        cur_data_d  = cur_data_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        vec_data_d  = vec_data_q;
        vec_valid_d = 1'b0;

        case (state_q)
            ST_START: begin
                state_d    = ST_SETUP;
                icw_idx_d  = 2'd0;
                cur_rd_d   = 1'b0;
                cur_a0_d   = 1'b0;
                cur_data_d = ICW1_VAL;
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = PULSE_LD;
            end
            ST_STROBE: begin
                if (cnt_q == '0) state_d = ST_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_HOLD: begin
                if (cur_rd_q) begin
                    rd_data_d  = DATA_IN;
                    rd_valid_d = 1'b1;
                end
                if (!init_done_q && nxt_vld) begin
                    state_d    = ST_SETUP;
                    icw_idx_d  = nxt_idx;
                    cur_rd_d   = 1'b0;
                    cur_a0_d   = 1'b1;
                    cur_data_d = icw_byte(nxt_idx);
                end else begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                // The interrupt wins; a simultaneous command simply stays pending.
                if (INT) begin
                    state_d = ST_INTA1;
                    cnt_d   = PULSE_LD;
                end else if (cmd_valid) begin
                    state_d    = ST_SETUP;
                    cur_rd_d   = cmd_rd;
                    cur_a0_d   = cmd_a0;
                    cur_data_d = cmd_data;
                end
            end
            ST_INTA1: begin
                if (cnt_q == '0) begin
                    state_d = ST_INTA_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_INTA_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_INTA2;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_INTA2: begin
                if (cnt_q == '0) state_d = ST_INTA_END;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_INTA_END: begin
                vec_data_d  = DATA_IN;
                vec_valid_d = 1'b1;
                state_d     = ST_VEC;
            end
            ST_VEC:  state_d = ST_READY;
            default: state_d = ST_START;
        endcase

        // Pin levels are registered from the next state so the strobes are glitch-free.
        wr_en_d  = (state_d == ST_STROBE) && !cur_rd_d;
        rd_en_d  = (state_d == ST_STROBE) && cur_rd_d;
        oe_d     = ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD))
                   && !cur_rd_d;
        inta_n_d = !((state_d == ST_INTA1) || (state_d == ST_INTA2));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_START;
            cnt_q       <= '0;
            icw_idx_q   <= 2'd0;
            init_done_q <= 1'b0;
            cur_rd_q    <= 1'b0;
            cur_a0_q    <= 1'b0;
            cur_data_q  <= 8'h00;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            vec_data_q  <= 8'h00;
            vec_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            oe_q        <= 1'b0;
            inta_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            icw_idx_q   <= icw_idx_d;
            init_done_q <= init_done_d;
            cur_rd_q    <= cur_rd_d;
            cur_a0_q    <= cur_a0_d;
            cur_data_q  <= cur_data_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            vec_data_q  <= vec_data_d;
            vec_valid_q <= vec_valid_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            oe_q        <= oe_d;
            inta_n_q    <= inta_n_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;
    assign init_done = init_done_q;
    assign WR_ENABLE = wr_en_q;
    assign RD_ENABLE = rd_en_q;
    assign A0        = cur_a0_q;
    assign DATA_OUT  = cur_data_q;
    assign DATA_OE   = oe_q;
    assign INTA_     = inta_n_q;

endmodule

// File: tb/tb_pic_host_bus_driver.sv
// Scoreboard bench for pic_host_bus_driver: a default instance and a cascade/IC4 instance.
module tb_pic_host_bus_driver;

    localparam int PULSE_W = 2;
    localparam int GAP_W   = 2;

    typedef enum logic [1:0] {EV_WR, EV_RD, EV_VEC} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic       a0;
        logic [7:0] data;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       cmd_valid, cmd_rd, cmd_a0;
    logic [7:0] cmd_data;
    logic [7:0] DATA_IN;
    logic       INT;
    logic       cmd_ready, rd_valid, vec_valid, init_done;
    logic [7:0] rd_data, vec_data, DATA_OUT;
    logic       WR_ENABLE, RD_ENABLE, A0, DATA_OE, INTA_;

    logic       cmd_valid_c, int_c;
    logic       cmd_ready_c, rd_valid_c, vec_valid_c, init_done_c;
    logic [7:0] rd_data_c, vec_data_c, DATA_OUT_c;
    logic       WR_ENABLE_c, RD_ENABLE_c, A0_c, DATA_OE_c, INTA_c;

    int n_checks = 0;
    int n_errors = 0;
    ev_t exp_a[$];
    ev_t exp_c[$];

    always #5 CLK = ~CLK;

    pic_host_bus_driver dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .vec_valid(vec_valid), .vec_data(vec_data), .init_done(init_done),
        .WR_ENABLE(WR_ENABLE), .RD_ENABLE(RD_ENABLE), .A0(A0),
        .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
        .INT(INT), .INTA_(INTA_)
    );

    pic_host_bus_driver #(.ICW1_VAL(8'h11)) dut_c (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid_c), .cmd_ready(cmd_ready_c), .cmd_rd(1'b0),
        .cmd_a0(1'b0), .cmd_data(8'h00),
        .rd_valid(rd_valid_c), .rd_data(rd_data_c),
        .vec_valid(vec_valid_c), .vec_data(vec_data_c), .init_done(init_done_c),
        .WR_ENABLE(WR_ENABLE_c), .RD_ENABLE(RD_ENABLE_c), .A0(A0_c),
        .DATA_OUT(DATA_OUT_c), .DATA_OE(DATA_OE_c), .DATA_IN(DATA_IN),
        .INT(int_c), .INTA_(INTA_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic sb_pop_a(input kind_t kind, input logic a0, input logic [7:0] data);
        ev_t e;
        if (exp_a.size() == 0) begin
            check("sb_a_unexpected_event", {30'd0, kind}, 32'hFFFF_FFFF);
        end else begin
            e = exp_a.pop_front();
            check("sb_a_kind", {30'd0, kind}, {30'd0, e.kind});
            if (kind != EV_VEC) check("sb_a_a0", {31'd0, a0}, {31'd0, e.a0});
            check("sb_a_data", {24'd0, data}, {24'd0, e.data});
        end
    endtask

    task automatic sb_pop_c(input logic a0, input logic [7:0] data);
        ev_t e;
        if (exp_c.size() == 0) begin
            check("sb_c_unexpected_write", {23'd0, a0, data}, 32'hFFFF_FFFF);
        end else begin
            e = exp_c.pop_front();
            check("sb_c_write", {23'd0, a0, data}, {23'd0, e.a0, e.data});
        end
    endtask

    task automatic push_a(input kind_t kind, input logic a0, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.a0   = a0;
        e.data = data;
        exp_a.push_back(e);
    endtask

    task automatic push_c(input logic a0, input logic [7:0] data);
        ev_t e;
        e.kind = EV_WR;
        e.a0   = a0;
        e.data = data;
        exp_c.push_back(e);
    endtask

    task automatic push_init;
        push_a(EV_WR, 1'b0, 8'h13);
        push_a(EV_WR, 1'b1, 8'h40);
        push_a(EV_WR, 1'b1, 8'h01);
        push_c(1'b0, 8'h11);
        push_c(1'b1, 8'h40);
        push_c(1'b1, 8'h00);
        push_c(1'b1, 8'h01);
    endtask

    // Drive one command, wait for acceptance, and count the clocks cmd_ready stays low.
    task automatic send_cmd(input logic rd, input logic a0, input logic [7:0] d,
                            output int low_clks);
        int n;
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_a0    = a0;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        low_clks = 0;
        @(negedge CLK);
        while (!cmd_ready && low_clks < 100) begin
            low_clks++;
            @(negedge CLK);
        end
    endtask

    logic wr_prev, rd_prev, inta_prev, wr_prev_c, wr_a0;
    logic [7:0] wr_dat;
    int wr_w, rd_w, inta_lo, inta_hi, inta_np;

    always @(negedge CLK) begin
        if (RESET) begin
            wr_prev   <= 1'b0;
            rd_prev   <= 1'b0;
            inta_prev <= 1'b1;
            wr_prev_c <= 1'b0;
            wr_w      <= 0;
            rd_w      <= 0;
            inta_lo   <= 0;
            inta_hi   <= 0;
            inta_np   <= 0;
        end else begin
            if (WR_ENABLE && !wr_prev) begin
                sb_pop_a(EV_WR, A0, DATA_OUT);
                check("wr_oe", {31'd0, DATA_OE}, 32'd1);
                wr_w   <= 1;
                wr_a0  <= A0;
                wr_dat <= DATA_OUT;
            end else if (WR_ENABLE) begin
                wr_w <= wr_w + 1;
            end
            if (!WR_ENABLE && wr_prev) begin
                check("wr_width", wr_w, PULSE_W);
                check("hold_oe", {31'd0, DATA_OE}, 32'd1);
                check("hold_addr_data", {23'd0, A0, DATA_OUT}, {23'd0, wr_a0, wr_dat});
            end
            wr_prev <= WR_ENABLE;

            if (RD_ENABLE && !rd_prev) begin
                check("rd_oe", {31'd0, DATA_OE}, 32'd0);
                rd_w <= 1;
            end else if (RD_ENABLE) begin
                rd_w <= rd_w + 1;
            end
            if (!RD_ENABLE && rd_prev) check("rd_width", rd_w, PULSE_W);
            rd_prev <= RD_ENABLE;

            if (!INTA_ && inta_prev) begin
                check("inta_oe", {31'd0, DATA_OE}, 32'd0);
                if (inta_np == 1) check("inta_gap", inta_hi, GAP_W);
                inta_lo <= 1;
            end else if (!INTA_) begin
                inta_lo <= inta_lo + 1;
            end
            if (INTA_ && !inta_prev) begin
                check("inta_low", inta_lo, PULSE_W);
                inta_hi <= 1;
                inta_np <= inta_np + 1;
            end else if (INTA_) begin
                inta_hi <= inta_hi + 1;
            end
            inta_prev <= INTA_;

            if (rd_valid) sb_pop_a(EV_RD, A0, rd_data);
            if (vec_valid) begin
                sb_pop_a(EV_VEC, 1'b0, vec_data);
                inta_np <= 0;
            end
            if (rd_valid && vec_valid) check("rd_vec_overlap", 32'd1, 32'd0);

            if (WR_ENABLE_c && !wr_prev_c) sb_pop_c(A0_c, DATA_OUT_c);
            wr_prev_c <= WR_ENABLE_c;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   low, n, falls;
        logic bad_rdy, prev;

        RESET       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_rd      = 1'b0;
        cmd_a0      = 1'b0;
        cmd_data    = 8'h00;
        DATA_IN     = 8'h00;
        INT         = 1'b0;
        cmd_valid_c = 1'b0;
        int_c       = 1'b0;
        repeat (2) @(negedge CLK);

        check("rst_wr", {31'd0, WR_ENABLE}, 32'd0);
        check("rst_rd", {31'd0, RD_ENABLE}, 32'd0);
        check("rst_inta", {31'd0, INTA_}, 32'd1);
        check("rst_a0", {31'd0, A0}, 32'd0);
        check("rst_dout", {24'd0, DATA_OUT}, 32'd0);
        check("rst_oe", {31'd0, DATA_OE}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
        check("rst_vec_data", {24'd0, vec_data}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);

        push_init();
        RESET   = 1'b0;
        bad_rdy = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge CLK);
            #1;
            if (i == 12) check("init_done_clk12", {31'd0, init_done}, 32'd0);
            if (i == 13) check("init_done_clk13", {31'd0, init_done}, 32'd1);
            if (i == 16) check("init_done_c_clk16", {31'd0, init_done_c}, 32'd0);
            if (i == 17) check("init_done_c_clk17", {31'd0, init_done_c}, 32'd1);
            if (!init_done_c && cmd_ready_c) bad_rdy = 1'b1;
        end
        check("c_ready_before_init", {31'd0, bad_rdy}, 32'd0);
        check("init_sb_a_empty", exp_a.size(), 32'd0);
        check("init_sb_c_empty", exp_c.size(), 32'd0);

        push_a(EV_WR, 1'b1, 8'hF0);
        send_cmd(1'b0, 1'b1, 8'hF0, low);
        check("wr_cmd_ready_low", low, 32'd4);
        repeat (2) @(negedge CLK);
        check("wr_sb_empty", exp_a.size(), 32'd0);

        DATA_IN = 8'hF0;
        push_a(EV_RD, 1'b1, 8'hF0);
        send_cmd(1'b1, 1'b1, 8'h00, low);
        check("rd_cmd_ready_low", low, 32'd4);
        repeat (2) @(negedge CLK);
        check("rd_sb_empty", exp_a.size(), 32'd0);

        // Interrupt and command raised together: vector must be reported before the write.
        DATA_IN = 8'h00;
        push_a(EV_VEC, 1'b0, 8'h43);
        push_a(EV_WR, 1'b0, 8'h5A);
        @(negedge CLK);
        INT       = 1'b1;
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_a0    = 1'b0;
        cmd_data  = 8'h5A;
        #1 check("int_blocks_ready", {31'd0, cmd_ready}, 32'd0);
        falls = 0;
        prev  = 1'b1;
        n     = 0;
        while (falls < 2 && n < 50) begin
            @(negedge CLK);
            n++;
            if (!INTA_ && prev) begin
                falls++;
                if (falls == 1) INT = 1'b0;
                if (falls == 2) DATA_IN = 8'h43;
            end
            prev = INTA_;
        end
        check("inta_falls", falls, 32'd2);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("cmd_after_vec_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        repeat (6) @(negedge CLK);
        check("int_sb_empty", exp_a.size(), 32'd0);

        // Reset in the middle of a write strobe, then the ICW sequence must restart.
        push_a(EV_WR, 1'b1, 8'h3C);
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_a0    = 1'b1;
        cmd_data  = 8'h3C;
        n = 0;
        while (!WR_ENABLE && n < 50) begin
            @(posedge CLK);
            #1;
            cmd_valid = 1'b0;
            n++;
        end
        check("reset_test_strobe_seen", {31'd0, WR_ENABLE}, 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("mid_reset_wr", {31'd0, WR_ENABLE}, 32'd0);
        check("mid_reset_oe", {31'd0, DATA_OE}, 32'd0);
        check("mid_reset_init_done", {31'd0, init_done}, 32'd0);
        @(negedge CLK);
        exp_a.delete();
        exp_c.delete();
        push_init();
        @(negedge CLK);
        RESET = 1'b0;
        n = 0;
        while (!(init_done && init_done_c) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        check("reinit_done", {30'd0, init_done, init_done_c}, 32'd3);
        check("reinit_sb_a_empty", exp_a.size(), 32'd0);
        check("reinit_sb_c_empty", exp_c.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pic_host_bus_driver.md
Name: pic_host_bus_driver

Overview:
- Processor-side initiator for the interrupt controller's host interface.
- After reset it writes the ICW initialization sequence automatically.
- Once initialized it forwards queued OCW/mask writes and status/mask reads as timed bus cycles.
- When INT rises it runs the two-pulse INTA_ acknowledge and captures the vector the controller drives. It sits between the CPU/bench model and the interrupt controller bus pins.

Parameters:
- ICW1_VAL, 8'h13, ICW1 byte (bit4=1 required; bit1=SNGL, bit0=IC4).
- ICW2_VAL, 8'h40, ICW2 byte (vector base, bits 7:3).
- ICW3_VAL, 8'h00, ICW3 byte; issued only when ICW1_VAL[1]=0.
- ICW4_VAL, 8'h01, ICW4 byte; issued only when ICW1_VAL[0]=1.
- PULSE_W, 2, strobe/INTA_ active width in clocks (>=1).
- GAP_W, 2, INTA_ high time between the two acknowledge pulses, in clocks (>=1).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_rd  in  1  1=read cycle, 0=write cycle.
- cmd_a0  in  1  A0 value for the command.
- cmd_data  in  8  write data.
- rd_valid  out  1  one-clock pulse; rd_data valid.
- rd_data  out  8  captured read byte.
- vec_valid  out  1  one-clock pulse; vec_data valid.
- vec_data  out  8  captured interrupt vector.
- init_done  out  1  ICW sequence complete.
- WR_ENABLE  out  1  active-high write strobe; controller latches on its rising edge.
- RD_ENABLE  out  1  active-high read strobe; controller updates read data on its falling edge.
- A0  out  1  address bit.
- DATA_OUT  out  8  bus write data.
- DATA_OE  out  1  1 = drive DATA_OUT onto the bus.
- DATA_IN  in  8  bus read data.
- INT  in  1  interrupt request from controller.
- INTA_  out  1  active-low interrupt acknowledge.

Behaviour:
- Reset values (async): WR_ENABLE=0, RD_ENABLE=0, INTA_=1, A0=0, DATA_OUT=0, DATA_OE=0, cmd_ready=0, rd_valid=0, rd_data=0, vec_valid=0, vec_data=0, init_done=0.
- After reset release, the FSM enters INIT_ICW1.
- Reset asserted mid-cycle aborts immediately; strobes return to inactive and the sequence restarts from INIT_ICW1.
- Bus cycle (shared sequencer): SETUP 1 clk → STROBE PULSE_W clks → HOLD 1 clk. Total PULSE_W+2 clocks.
  - SETUP: A0/DATA_OUT/DATA_OE valid, strobe inactive.
  - STROBE: strobe active, address/data unchanged.
  - HOLD: strobe inactive, A0/DATA_OUT held.
  - On a read, DATA_IN is sampled into rd_data at the end of HOLD; rd_valid pulses the next clock.
  - DATA_OE=1 only during write cycles, SETUP through HOLD; 0 for reads and INTA.
- Init FSM: INIT_ICW1 (A0=0, ICW1_VAL) → INIT_ICW2 (A0=1) → INIT_ICW3 (A0=1, only if ICW1_VAL[1]=0) → INIT_ICW4 (A0=1, only if ICW1_VAL[0]=1) → READY.
  - Consecutive ICW cycles are back-to-back: the next SETUP follows HOLD directly.
  - init_done rises the clock after the last HOLD and stays 1 until reset.
  - INT is ignored during init.
- READY:
  - cmd_ready=1 only in READY with INT=0.
  - On accept, the command is registered and the bus cycle starts the next clock.
  - cmd_ready=0 until the cycle completes.
- Interrupt has priority. In READY with INT=1 (sampled), the FSM enters INTA1 and no command is accepted.
  - INTA1: INTA_=0 for PULSE_W clocks.
  - INTA_GAP: INTA_=1 for GAP_W clocks.
  - INTA2: INTA_=0 for PULSE_W clocks.
  - INTA_END: INTA_=1 for 1 clock; DATA_IN is captured into vec_data on this clock.
  - vec_valid pulses the next clock, then the FSM returns to READY.
- INT rising during a bus cycle is serviced after HOLD completes.
- INT falling mid-INTA does not abort; the sequence completes and the captured value is reported as is.
- cmd_valid and INT both set in the same READY clock: the interrupt wins and the command stays pending, not dropped.
- rd_valid and vec_valid never both assert in the same clock.

Test Plan:
- Defaults, release RESET → exactly 3 writes: (A0=0, 0x13), (A0=1, 0x40), (A0=1, 0x01). Each WR_ENABLE pulse is 2 clks wide; init_done=1 at clock 13 after release.
- ICW1_VAL=8'h11 (cascade, IC4) → 4 writes including ICW3 (A0=1, 0x00) before ICW4; no cmd_ready before init_done.
- Write command a0=1, data=0xF0 → WR_ENABLE high 2 clks, A0=1, DATA_OE=1, DATA_OUT=0xF0 held through HOLD; cmd_ready low 4 clks.
- Read command a0=1, DATA_IN=0xF0 → RD_ENABLE pulse; rd_valid one clk with rd_data=0xF0; DATA_OE stays 0.
- INT=1 in READY, DATA_IN=0x43 after the 2nd INTA_ fall → INTA_ low 2, high 2, low 2 clocks; vec_valid pulse with vec_data=0x43; cmd_valid raised in the same clock as INT is accepted only after vec_valid.
- RESET asserted during a STROBE clock → WR_ENABLE=0 the same instant; init_done=0; the ICW1 write is re-issued after release.
